glyph_reader: RTL and testbench

GLYPH_READER -- requirements
Module: glyph_reader

---
 rtl/glyph_reader_pkg.sv | 59 +++++
 rtl/glyph_reader_if.sv | 24 ++
 rtl/glyph_reader_rom.sv | 25 ++
 rtl/glyph_reader.sv | 133 +++++++++++++
 tb/tb_glyph_reader.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glyph_reader_pkg.sv
// Shared constants for the glyph reader: cell geometry, glyph bitmaps,
// note codes and FSM state encoding.
package glyph_reader_pkg;
  localparam int CELL      = 12;
  localparam int CELL_BITS = CELL * CELL;
  localparam int NCELLS    = 3;

  typedef logic [CELL_BITS-1:0] glyph_t;
  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_MATCH, ST_RESULT} state_t;

  localparam logic [3:0] NOTE_NONE = 4'd0, NOTE_A = 4'd1, NOTE_AS = 4'd2, NOTE_B = 4'd3,
                         NOTE_C = 4'd4, NOTE_CS = 4'd5, NOTE_D = 4'd6, NOTE_DS = 4'd7,
                         NOTE_E = 4'd8, NOTE_F = 4'd9, NOTE_FS = 4'd10, NOTE_G = 4'd11,
                         NOTE_GS = 4'd12;

  // Candidate scan order: letters A..G = 0..6, sharp = 7, digits 1..4 = 8..11
  localparam logic [3:0] CAND_SHARP = 4'd7, CAND_ONE = 4'd8, CAND_LAST = 4'd11;

  // Bitmaps: MSB = row 0 col 0, row-major, 12 bits per row
  localparam glyph_t GLYPH_A = {12'h060, 12'h0F0, 12'h198, 12'h30C, 12'h30C, 12'h3FC,
                                12'h3FC, 12'h30C, 12'h30C, 12'h30C, 12'h30C, 12'h000};
  localparam glyph_t GLYPH_B = {12'h3F8, 12'h30C, 12'h30C, 12'h30C, 12'h3F8, 12'h3F8,
                                12'h30C, 12'h30C, 12'h30C, 12'h30C, 12'h3F8, 12'h000};
  localparam glyph_t GLYPH_C = {12'h0F8, 12'h18C, 12'h300, 12'h300, 12'h300, 12'h300,
                                12'h300, 12'h300, 12'h300, 12'h18C, 12'h0F8, 12'h000};
  localparam glyph_t GLYPH_D = {12'h3F0, 12'h318, 12'h30C, 12'h30C, 12'h30C, 12'h30C,
                                12'h30C, 12'h30C, 12'h30C, 12'h318, 12'h3F0, 12'h000};
  localparam glyph_t GLYPH_E = {12'h3FC, 12'h300, 12'h300, 12'h300, 12'h3F8, 12'h3F8,
                                12'h300, 12'h300, 12'h300, 12'h300, 12'h3FC, 12'h000};
  localparam glyph_t GLYPH_F = {12'h3FC, 12'h300, 12'h300, 12'h300, 12'h3F8, 12'h3F8,
                                12'h300, 12'h300, 12'h300, 12'h300, 12'h300, 12'h000};
  localparam glyph_t GLYPH_G = {12'h0F8, 12'h18C, 12'h300, 12'h300, 12'h300, 12'h33C,
                                12'h30C, 12'h30C, 12'h30C, 12'h18C, 12'h0F8, 12'h000};
  localparam glyph_t GLYPH_SHARP = {12'h000, 12'h198, 12'h198, 12'h7FE, 12'h198, 12'h198,
                                    12'h198, 12'h7FE, 12'h198, 12'h198, 12'h000, 12'h000};
  localparam glyph_t GLYPH_ONE   = {12'h060, 12'h0E0, 12'h1E0, 12'h060, 12'h060, 12'h060,
                                    12'h060, 12'h060, 12'h060, 12'h060, 12'h1F8, 12'h000};
  localparam glyph_t GLYPH_TWO   = {12'h0F0, 12'h198, 12'h00C, 12'h00C, 12'h018, 12'h030,
                                    12'h060, 12'h0C0, 12'h180, 12'h300, 12'h3FC, 12'h000};
  localparam glyph_t GLYPH_THREE = {12'h3F8, 12'h00C, 12'h00C, 12'h00C, 12'h0F8, 12'h0F8,
                                    12'h00C, 12'h00C, 12'h00C, 12'h00C, 12'h3F8, 12'h000};
  localparam glyph_t GLYPH_FOUR  = {12'h018, 12'h038, 12'h078, 12'h0D8, 12'h198, 12'h318,
                                    12'h3FC, 12'h3FC, 12'h018, 12'h018, 12'h018, 12'h000};

  // Letter index 0..6 (A..G) plus sharp flag -> note code
  function automatic logic [3:0] note_code(input logic [2:0] letter, input logic sharp);
    logic [3:0] base;
    case (letter)
      3'd0:    base = NOTE_A;
      3'd1:    base = NOTE_B;
      3'd2:    base = NOTE_C;
      3'd3:    base = NOTE_D;
      3'd4:    base = NOTE_E;
      3'd5:    base = NOTE_F;
      default: base = NOTE_G;
    endcase
    return base + {3'b000, sharp};
  endfunction
endpackage

// File: rtl/glyph_reader_if.sv
// Capture/result bus between the pixel source, the glyph reader and its consumer.
interface glyph_reader_if;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic       start;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot_en;
  logic       frame_done;
  logic       ready;
  logic [3:0] note;
  logic [1:0] octave;
  logic       valid;
  logic       error;
  logic       busy;

  modport master(output base_x, base_y, start, plot_x, plot_y, plot_colour, plot_en,
                 frame_done, ready,
                 input note, octave, valid, error, busy);
  modport slave(input base_x, base_y, start, plot_x, plot_y, plot_colour, plot_en,
                frame_done, ready,
                output note, octave, valid, error, busy);
endinterface

// File: rtl/glyph_reader_rom.sv
// Candidate glyph ROM: scan index -> 144-bit reference bitmap.
module glyph_rom
  import glyph_reader_pkg::*;
(
  input  logic [3:0] idx,
  output glyph_t     pat
);
  always_comb begin
    case (idx)
      4'd0:    pat = GLYPH_A;
      4'd1:    pat = GLYPH_B;
      4'd2:    pat = GLYPH_C;
      4'd3:    pat = GLYPH_D;
      4'd4:    pat = GLYPH_E;
      4'd5:    pat = GLYPH_F;
      4'd6:    pat = GLYPH_G;
      4'd7:    pat = GLYPH_SHARP;
      4'd8:    pat = GLYPH_ONE;
      4'd9:    pat = GLYPH_TWO;
      4'd10:   pat = GLYPH_THREE;
      4'd11:   pat = GLYPH_FOUR;
      default: pat = '0;
    endcase
  end
endmodule

// File: rtl/glyph_reader.sv
// Captures a 3-cell note label out of a pixel-write stream, then matches each
// cell against the glyph ROM (one candidate per cycle) and reports the note.
module glyph_reader
  import glyph_reader_pkg::*;
(
  input logic clk,
  input logic resetn,
  glyph_reader_if.slave bus
);
  state_t state, state_nx;
  logic [7:0] bx_q;
  logic [6:0] by_q;
  glyph_t [NCELLS-1:0] cells;
  logic [3:0] idx;
  glyph_t rom_pat, cand;
  logic hit, last;
  logic let_hit, oct_hit, sh_hit;
  logic [2:0] let_idx;
  logic [1:0] oct_idx;
  logic [3:0] note_q;
  logic [1:0] oct_q;
  logic err_q;
  logic [8:0] dx, dy;
  logic in_win;
  logic [1:0] cell_sel;
  logic [3:0] col;
  logic [7:0] bit_idx;
  logic fin_oct, fin_ok, blank_c;
  logic [1:0] fin_oct_idx;

  glyph_rom u_rom (.idx(idx), .pat(rom_pat));

  // 9-bit offsets: a borrow shows up as a huge value, and the >= guards reject it
  assign dx = {1'b0, bus.plot_x} - {1'b0, bx_q};
  assign dy = {2'b00, bus.plot_y} - {2'b00, by_q};
  assign in_win = (bus.plot_x >= bx_q) && (bus.plot_y >= by_q) &&
                  (dx < 9'(NCELLS * CELL)) && (dy < 9'(CELL));

  always_comb begin
    cell_sel = 2'd2;
    col      = 4'(dx - 9'd24);
    if (dx < 9'd12) begin
      cell_sel = 2'd0;
      col      = dx[3:0];
    end else if (dx < 9'd24) begin
      cell_sel = 2'd1;
      col      = 4'(dx - 9'd12);
    end
  end
  assign bit_idx = 8'(CELL_BITS - 1) - (8'(dy[3:0]) * 8'(CELL) + 8'(col));

  // Letters live in cell 1, the sharp in cell 0, the octave digit in cell 2
  always_comb begin
    cand = cells[2];
    if (idx < CAND_SHARP)       cand = cells[1];
    else if (idx == CAND_SHARP) cand = cells[0];
  end
  assign hit  = (cand == rom_pat);
  assign last = (idx == CAND_LAST);

  // The final candidate is digit "4"; fold its compare in directly
  assign fin_oct     = oct_hit | hit;
  assign fin_oct_idx = hit ? 2'd3 : oct_idx;
  assign blank_c     = (cells[0] == '0);
  assign fin_ok      = let_hit && fin_oct && (sh_hit || blank_c) &&
                       !(sh_hit && (let_idx == 3'd1 || let_idx == 3'd4));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.start) state_nx = ST_CAPTURE;
    else begin
      case (state)
        ST_CAPTURE: if (bus.frame_done) state_nx = ST_MATCH;
        ST_MATCH:   if (last)           state_nx = ST_RESULT;
        ST_RESULT:  if (bus.ready)      state_nx = ST_IDLE;
        default:    ;
      endcase
    end
  end

  always_comb begin
    bus.busy  = (state == ST_CAPTURE) || (state == ST_MATCH);
    bus.valid = (state == ST_RESULT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bx_q <= '0; by_q <= '0; cells <= '0; idx <= '0;
      let_hit <= 1'b0; oct_hit <= 1'b0; sh_hit <= 1'b0;
      let_idx <= '0; oct_idx <= '0;
      note_q <= NOTE_NONE; oct_q <= '0; err_q <= 1'b0;
    end else begin
      if (bus.start) begin
        bx_q  <= bus.base_x;
        by_q  <= bus.base_y;
        cells <= '0;
      end else if (state == ST_CAPTURE && bus.plot_en && in_win) begin
        cells[cell_sel][bit_idx] <= |bus.plot_colour;
      end
      if (state == ST_MATCH && !bus.start) begin
        idx <= idx + 4'd1;
        if (idx < CAND_SHARP && hit) begin
          let_hit <= 1'b1;
          let_idx <= idx[2:0];
        end
        if (idx == CAND_SHARP) sh_hit <= hit;
        if (idx >= CAND_ONE && hit) begin
          oct_hit <= 1'b1;
          oct_idx <= 2'(idx - CAND_ONE);
        end
        if (last) begin
          note_q <= fin_ok ? note_code(let_idx, sh_hit) : NOTE_NONE;
          oct_q  <= fin_ok ? fin_oct_idx : 2'd0;
          err_q  <= !fin_ok;
        end
      end else begin
        idx     <= '0;
        let_hit <= 1'b0;
        oct_hit <= 1'b0;
        sh_hit  <= 1'b0;
      end
    end
  end

  assign bus.note   = note_q;
  assign bus.octave = oct_q;
  assign bus.error  = err_q;
endmodule

// File: tb/tb_glyph_reader.sv
// Scoreboard bench for glyph_reader: directed label scenarios plus random
// labels decoded by a pixel-image reference model.
module tb_glyph_reader;
  import glyph_reader_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  glyph_reader_if bus();

  glyph_reader dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] note;
    logic [1:0] oct;
    logic       err;
    int         fd_cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  bit rdy_auto = 0, noise = 0;
  int cur_bx, cur_by;
  bit img [36][12];
  glyph_t letters [7];
  glyph_t digits [4];
  string let_nm [7];
  string note_nm [12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rdy_auto) bus.ready = ($urandom_range(0, 3) != 0);
    if (noise) begin
      bus.plot_en     = 1'($urandom_range(0, 1));
      bus.plot_x      = 8'($urandom);
      bus.plot_y      = 7'($urandom);
      bus.plot_colour = 3'($urandom);
    end
  endtask

  // Reference model: a 36x12 picture of the label window
  task automatic plot(input int x, input int y, input logic [2:0] col);
    bus.plot_x = 8'(x); bus.plot_y = 7'(y); bus.plot_colour = col; bus.plot_en = 1'b1;
    if (x >= cur_bx && x < cur_bx + 36 && y >= cur_by && y < cur_by + 12)
      img[x - cur_bx][y - cur_by] = (col != 3'd0);
    tick();
    bus.plot_en = 1'b0;
  endtask

  task automatic do_start(input int bx, input int by, input bit stray);
    bus.base_x = 8'(bx); bus.base_y = 7'(by); bus.start = 1'b1;
    cur_bx = bx; cur_by = by;
    foreach (img[i, j]) img[i][j] = 1'b0;
    if (stray) begin
      // row 11 is blank in every glyph, so an accepted write here would show
      bus.plot_x = 8'(bx + 12 * $urandom_range(0, 2) + $urandom_range(0, 11));
      bus.plot_y = 7'(by + 11);
      bus.plot_colour = 3'd7;
      bus.plot_en = 1'b1;
    end
    tick();
    bus.start = 1'b0; bus.plot_en = 1'b0;
  endtask

  task automatic draw(input int c, input glyph_t pat);
    for (int r = 0; r < 12; r++)
      for (int k = 0; k < 12; k++)
        if (pat[143 - (r * 12 + k)])
          plot(cur_bx + c * 12 + k, cur_by + r, 3'($urandom_range(1, 7)));
  endtask

  function automatic glyph_t cell_pat(input int c);
    glyph_t p;
    for (int r = 0; r < 12; r++)
      for (int k = 0; k < 12; k++)
        p[143 - (r * 12 + k)] = img[c * 12 + k][r];
    return p;
  endfunction

  task automatic model_decode(output logic [3:0] n, output logic [1:0] o, output logic e);
    glyph_t c0, c1, c2;
    int li, oi;
    string nm;
    c0 = cell_pat(0); c1 = cell_pat(1); c2 = cell_pat(2);
    li = -1; oi = -1;
    for (int i = 0; i < 7; i++) if (c1 == letters[i]) li = i;
    for (int i = 0; i < 4; i++) if (c2 == digits[i]) oi = i;
    n = 4'd0; o = 2'd0; e = 1'b1;
    if (li >= 0 && oi >= 0 && (c0 == '0 || c0 == GLYPH_SHARP)) begin
      nm = let_nm[li];
      if (c0 != '0) nm = {nm, "#"};
      for (int j = 0; j < 12; j++)
        if (note_nm[j] == nm) begin
          n = 4'(j + 1); o = 2'(oi); e = 1'b0;
        end
    end
  endtask

  task automatic frame_end(input bit push, input logic [3:0] n, input logic [1:0] o,
                           input logic e);
    exp_t x;
    bus.frame_done = 1'b1;
    if (push) begin
      x.note = n; x.oct = o; x.err = e; x.fd_cyc = cyc + 1;
      exp_q.push_back(x);
    end
    tick();
    bus.frame_done = 1'b0;
  endtask

  task automatic wait_result();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) begin
      chk("result_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    noise = 0; bus.plot_en = 1'b0;
  endtask

  // Monitor: pops the scoreboard when a result is presented
  initial begin
    bit held, acc;
    logic [6:0] hv;
    exp_t e;
    held = 0; acc = 0; hv = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        held = 0; acc = 0;
      end else begin
        if (acc) begin
          chk("valid_drop", 32'(bus.valid), 0);
          acc = 0;
        end
        if (bus.valid) begin
          if (!held) begin
            if (exp_q.size() == 0) chk("spurious_valid", 32'(bus.valid), 0);
            else begin
              e = exp_q[0];
              chk("latency", 32'(cyc - e.fd_cyc), 12);
              chk("note", 32'(bus.note), 32'(e.note));
              chk("octave", 32'(bus.octave), 32'(e.oct));
              chk("error", 32'(bus.error), 32'(e.err));
              hv = {bus.note, bus.octave, bus.error};
              held = 1;
            end
          end else chk("hold_stable", 32'({bus.note, bus.octave, bus.error}), 32'(hv));
          if (bus.ready) begin
            if (held) void'(exp_q.pop_front());
            held = 0; acc = 1;
          end
        end else if (held) begin
          chk("valid_held", 32'(bus.valid), 1);
          void'(exp_q.pop_front());
          held = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] n;
    logic [1:0] o;
    logic e;
    letters = '{GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F, GLYPH_G};
    digits  = '{GLYPH_ONE, GLYPH_TWO, GLYPH_THREE, GLYPH_FOUR};
    let_nm  = '{"A", "B", "C", "D", "E", "F", "G"};
    note_nm = '{"A", "A#", "B", "C", "C#", "D", "D#", "E", "F", "F#", "G", "G#"};

    resetn = 1'b0;
    bus.base_x = '0; bus.base_y = '0; bus.start = 1'b0; bus.plot_x = '0; bus.plot_y = '0;
    bus.plot_colour = '0; bus.plot_en = 1'b0; bus.frame_done = 1'b0; bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_note", 32'(bus.note), 0);
    chk("rst_octave", 32'(bus.octave), 0);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_error", 32'(bus.error), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    resetn = 1'b1;
    tick();

    // C, octave "3", blank sharp cell
    do_start(10, 20, 0);
    chk("capture_busy", 32'(bus.busy), 1);
    draw(1, GLYPH_C); draw(2, GLYPH_THREE);
    frame_end(1, 4'd4, 2'd2, 1'b0);
    chk("match_busy", 32'(bus.busy), 1);
    wait_result();

    // C#3
    do_start(10, 20, 0);
    draw(0, GLYPH_SHARP); draw(1, GLYPH_C); draw(2, GLYPH_THREE);
    frame_end(1, 4'd5, 2'd2, 1'b0);
    wait_result();

    // B#1 is not a legal note
    do_start(10, 20, 0);
    draw(0, GLYPH_SHARP); draw(1, GLYPH_B); draw(2, GLYPH_ONE);
    frame_end(1, 4'd0, 2'd0, 1'b1);
    wait_result();

    // E4 with the consumer stalling
    bus.ready = 1'b0;
    do_start(10, 20, 0);
    draw(1, GLYPH_E); draw(2, GLYPH_FOUR);
    frame_end(1, 4'd8, 2'd3, 1'b0);
    repeat (32) tick();
    chk("stall_valid", 32'(bus.valid), 1);
    chk("stall_busy", 32'(bus.busy), 0);
    bus.ready = 1'b1;
    wait_result();
    chk("after_accept_valid", 32'(bus.valid), 0);

    // A2 with writes just outside the window
    do_start(10, 20, 0);
    draw(1, GLYPH_A);
    plot(9, 20, 3'd5); plot(46, 20, 3'd1); plot(15, 19, 3'd2); plot(15, 32, 3'd3);
    draw(2, GLYPH_TWO);
    plot(9, 31, 3'd7); plot(46, 31, 3'd7);
    frame_end(1, 4'd1, 2'd1, 1'b0);
    wait_result();

    // Restart mid-MATCH discards the label; empty frame gives an error
    do_start(10, 20, 0);
    draw(1, GLYPH_C); draw(2, GLYPH_THREE);
    frame_end(0, 4'd0, 2'd0, 1'b0);
    repeat (4) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("restart_busy", 32'(bus.busy), 1);
      chk("restart_no_valid", 32'(bus.valid), 0);
      tick();
    end
    frame_end(1, 4'd0, 2'd0, 1'b1);
    wait_result();

    // Reset mid-CAPTURE: outputs clear without a clock edge
    do_start(30, 40, 0);
    draw(1, GLYPH_D);
    chk("pre_reset_busy", 32'(bus.busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_note", 32'(bus.note), 0);
    chk("arst_octave", 32'(bus.octave), 0);
    chk("arst_valid", 32'(bus.valid), 0);
    chk("arst_error", 32'(bus.error), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    tick(); tick();
    resetn = 1'b1;
    repeat (20) tick();
    chk("post_reset_busy", 32'(bus.busy), 0);

    // Random labels against the image model
    rdy_auto = 1;
    for (int t = 0; t < 30; t++) begin
      int bx, by, li, oi, mode, cx, cy;
      int nx [3];
      int ny [3];
      bx = $urandom_range(1, 219); by = $urandom_range(1, 115);
      li = $urandom_range(0, 6); oi = $urandom_range(0, 3); mode = $urandom_range(0, 4);
      do_start(bx, by, 1);
      for (int k = 0; k < 3; k++) begin
        nx[k] = bx + $urandom_range(0, 35); ny[k] = by + $urandom_range(0, 11);
        plot(nx[k], ny[k], 3'($urandom_range(1, 7)));
      end
      for (int k = 0; k < 3; k++) plot(nx[k], ny[k], 3'd0);
      if ($urandom_range(0, 1) == 1) draw(0, GLYPH_SHARP);
      draw(1, letters[li]);
      if (mode != 1) draw(2, digits[oi]);
      plot(bx - 1, by + $urandom_range(0, 11), 3'd6);
      plot(bx + 36, by + $urandom_range(0, 11), 3'd6);
      plot(bx + $urandom_range(0, 35), by - 1, 3'd6);
      plot(bx + $urandom_range(0, 35), by + 12, 3'd6);
      if (mode == 0) begin
        cx = $urandom_range(0, 35); cy = $urandom_range(0, 11);
        plot(bx + cx, by + cy, img[cx][cy] ? 3'd0 : 3'($urandom_range(1, 7)));
      end
      model_decode(n, o, e);
      frame_end(1, n, o, e);
      noise = 1;
      wait_result();
    end
    rdy_auto = 0;
    bus.ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
